// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte-stream requesters.
// Each grant covers one burst, ended by req_last, a dropped req or the MAX_BURST byte budget.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                   uart_clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             pick_found;
  logic [CNT_W-1:0] burst_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             last_q;
  logic             sel_req;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             accept;
  logic             cnt_max;
  logic             to_expired;
  logic             rel_burst;

  // Owner's request signals, selected by the registered grant index.
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx == IDX_W'(i)) begin
        sel_req   = req[i];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // First requester above rr_ptr; scanning downward lets the nearest candidate win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % int'(NUM_REQ));
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign accept     = (state == ST_GRANT) && sel_valid && !tx_busy;
  assign cnt_max    = (burst_cnt == CNT_W'(MAX_BURST));
  assign to_expired = (to_cnt == TO_W'(BUSY_TIMEOUT - 1));
  assign rel_burst  = ((state == ST_GRANT) && !accept && !sel_req) ||
                      ((state == ST_WAIT_DONE) && !tx_busy && (last_q || cnt_max || !sel_req));

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_found) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (accept)         state_nxt = ST_LAUNCH;
        else if (rel_burst) state_nxt = ST_IDLE;
      end
      ST_LAUNCH: begin
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy || to_expired) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_nxt = rel_burst ? ST_IDLE : ST_GRANT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // req_ready never looks at req_valid, so producers can wait on it without a loop.
  always_comb begin
    req_ready = '0;
    tx_start  = 1'b0;
    if (state == ST_GRANT) req_ready = grant & {NUM_REQ{!tx_busy}};
    if (state == ST_LAUNCH) tx_start = 1'b1;
  end

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      to_cnt    <= '0;
      last_q    <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      if ((state == ST_IDLE) && pick_found) begin
        grant     <= NUM_REQ'(1) << pick_idx;
        gidx      <= pick_idx;
        burst_cnt <= '0;
      end
      if (accept) begin
        tx_data <= sel_data;
        last_q  <= sel_last;
        if (!cnt_max) burst_cnt <= burst_cnt + 1'b1;
      end
      // Pointer moves only on release, which bounds the wait to NUM_REQ-1 bursts.
      if (rel_burst) begin
        grant  <= '0;
        rr_ptr <= gidx;
      end
      if (state == ST_LAUNCH) begin
        to_cnt <= '0;
      end else if (state == ST_WAIT_BUSY) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule
